// File: rtl/bitonic_serializer_pkg.sv
// Shared constants and FSM encoding for the bitonic vector serializer.
package bitonic_serializer_pkg;

    localparam int unsigned NUM_DEF = 4;
    localparam int unsigned W_DEF   = 16;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/bitonic_serializer.sv
// Captures one sorted vector of NUM records and emits it one record per
// output transfer, ascending or descending, with a valid/ready handshake.
module bitonic_serializer
    import bitonic_serializer_pkg::*;
#(
    parameter int unsigned NUM = NUM_DEF,
    parameter int unsigned W   = W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM*W-1:0]         in_data,
    input  logic                     in_reverse,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(NUM)-1:0]   out_idx,
    output logic                     out_last,
    output logic                     busy
);

    localparam int unsigned IDXW = $clog2(NUM);

    state_t             r_state;
    logic [NUM*W-1:0]   r_hold;
    logic               r_rev;
    logic [IDXW-1:0]    r_cnt;

    logic               w_out_valid;
    logic               w_last;
    logic               w_in_ready;
    logic               w_in_xfer;
    logic               w_out_xfer;
    logic [IDXW-1:0]    w_sel;
    logic [W-1:0]       w_rec;

    assign w_out_valid = (r_state == SEND);
    assign w_last      = w_out_valid && (r_cnt == IDXW'(NUM - 1));
    // A new vector may enter in the same cycle the last record leaves.
    assign w_in_ready  = !w_out_valid || (w_last && out_ready);
    assign w_in_xfer   = in_valid && w_in_ready;
    assign w_out_xfer  = w_out_valid && out_ready;

    // Record select: position cnt counted from the low or the high end.
    assign w_sel = r_rev ? (IDXW'(NUM - 1) - r_cnt) : r_cnt;

    always_comb begin
        w_rec = '0;
        for (int unsigned i = 0; i < NUM; i++) begin
            if (w_sel == IDXW'(i)) begin
                w_rec = r_hold[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
            r_rev   <= 1'b0;
            r_cnt   <= '0;
        end else if (w_in_xfer) begin
            r_state <= SEND;
            r_hold  <= in_data;
            r_rev   <= in_reverse;
            r_cnt   <= '0;
        end else if (w_out_xfer) begin
            // cnt parks on the final index until the next capture reloads it.
            if (w_last) begin
                r_state <= IDLE;
            end else begin
                r_cnt <= r_cnt + IDXW'(1);
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = w_rec;
    assign out_idx   = r_cnt;
    assign out_last  = w_last;
    assign busy      = w_out_valid;

endmodule

// File: tb/tb_bitonic_serializer.sv
// Directed bench for bitonic_serializer: forward, reverse, backpressure,
// back-to-back vectors and reset in the middle of a vector.
module tb_bitonic_serializer;

    localparam int unsigned NUM = 4;
    localparam int unsigned W   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid;
    logic               in_ready;
    logic [NUM*W-1:0]   in_data;
    logic               in_reverse;
    logic               out_valid;
    logic               out_ready;
    logic [W-1:0]       out_data;
    logic [1:0]         out_idx;
    logic               out_last;
    logic               busy;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [NUM*W-1:0] VEC_A = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    localparam logic [NUM*W-1:0] VEC_B = {16'h0008, 16'h0007, 16'h0006, 16'h0005};

    bitonic_serializer #(.NUM(NUM), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_reverse (in_reverse),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_rec(input string tag, input logic [15:0] d, input int idx,
                             input logic last, input logic rdy);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_busy"},  32'(busy),      32'd1);
        chk({tag, "_data"},  32'(out_data),  32'(d));
        chk({tag, "_idx"},   32'(out_idx),   32'(idx));
        chk({tag, "_last"},  32'(out_last),  32'(last));
        chk({tag, "_rdy"},   32'(in_ready),  32'(rdy));
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
        chk({tag, "_rdy"},   32'(in_ready),  32'd1);
    endtask

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        in_reverse = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        #2;
        check_idle("rst");
        chk("rst_idx",  32'(out_idx),  32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("rel_rdy", 32'(in_ready), 32'd1);
        tick();

        // Forward
        in_data = VEC_A; in_reverse = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("fwd_cap_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_rec($sformatf("fwd%0d", k), 16'(k + 1), k, k == 3, k == 3);
            tick();
        end
        #1;
        check_idle("fwd_end");

        // Reverse
        in_data = VEC_A; in_reverse = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_reverse = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_rec($sformatf("rev%0d", k), 16'(4 - k), k, k == 3, k == 3);
            tick();
        end
        #1;
        check_idle("rev_end");

        // Backpressure at cnt=1 with a competing vector offered
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check_rec("bp0", 16'h0001, 0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0; in_valid = 1'b1; in_data = VEC_B; in_reverse = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_rec($sformatf("bp_hold%0d", k), 16'h0002, 1, 1'b0, 1'b0);
            tick();
        end
        out_ready = 1'b1; in_valid = 1'b0; in_reverse = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            check_rec($sformatf("bp%0d", k), 16'(k + 1), k, k == 3, k == 3);
            tick();
        end
        #1;
        check_idle("bp_end");

        // Back-to-back vectors
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_data = VEC_B;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_rec($sformatf("b2b%0d", k), 16'(k + 1), k % 4, (k % 4) == 3, (k % 4) == 3);
            tick();
            if (k == 3) in_valid = 1'b0;
        end
        #1;
        check_idle("b2b_end");

        // Reset mid-vector
        in_data = VEC_A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_idle("mrst");
        chk("mrst_idx",  32'(out_idx),  32'd0);
        chk("mrst_data", 32'(out_data), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_rel_rdy", 32'(in_ready), 32'd1);
        in_data = VEC_B; in_reverse = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_reverse = 1'b0;
        #1;
        check_rec("post0", 16'h0008, 0, 1'b0, 1'b0);
        tick();
        #1;
        check_rec("post1", 16'h0007, 1, 1'b0, 1'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
